mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, meaning the data memory word width.
REQ-002 SHALL have parameter ADDR_W, default 11, meaning the data memory address width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port op_valid, input, 1 bit: an EX/MEM memory request is present.
REQ-006 SHALL have port op, input, 3 bits: request code, one of NOP=0, LOAD=1, STORE=2, PUSH=3, POP=4, PUSH2=5, POP2=6.
REQ-007 SHALL have port ea, input, ADDR_W bits: effective address for LOAD/STORE.
REQ-008 SHALL have port wdata, input, 2*WORD_SIZE bits: store/push data; single-word ops use bits [15:0].
REQ-009 SHALL have port stall, output, 1 bit: upstream holds op/ea/wdata stable this cycle.
REQ-010 SHALL have ports mem_read/mem_write (output, 1 bit each), mem_addr (output, ADDR_W), mem_wd (output, WORD_SIZE), mem_rd (input, WORD_SIZE): the data memory port; mem_rd is the word at mem_addr in the same cycle.
REQ-011 SHALL have ports rdata (output, 2*WORD_SIZE) and rdata_valid (output, 1 bit): registered read result to write-back.
REQ-012 SHALL have port sp, output, ADDR_W bits: current stack pointer.

Function
REQ-013 SHALL implement FSM states IDLE and SECOND; op_valid with op outside 1..6 is treated as NOP.
REQ-014 SHALL, in IDLE with LOAD: mem_read=1, mem_addr=ea; rdata={16'b0,mem_rd}, rdata_valid=1 on the next cycle.
REQ-015 SHALL, in IDLE with STORE: mem_write=1, mem_addr=ea, mem_wd=wdata[15:0]; no rdata_valid.
REQ-016 SHALL, for PUSH: write wdata[15:0] at sp, then sp <= sp-1 (post-decrement, full-descending stack).
REQ-017 SHALL, for POP: read at sp+1, sp <= sp+1; rdata={16'b0,mem_rd}, rdata_valid=1 next cycle.
REQ-018 SHALL, for PUSH2: IDLE cycle writes wdata[31:16] at sp with stall=1 -> SECOND; SECOND cycle writes wdata[15:0] at sp-1, sp <= sp-2, stall=0 -> IDLE.
REQ-019 SHALL, for POP2: IDLE cycle reads low word at sp+1 into holding register with stall=1 -> SECOND; SECOND cycle reads high word at sp+2, sp <= sp+2 -> IDLE; rdata={high,low}, rdata_valid=1 the following cycle.
REQ-020 SHALL keep sp unchanged during the first cycle of PUSH2/POP2; sp is updated only at op completion.
REQ-021 SHALL compute all sp and address arithmetic modulo 2**ADDR_W (sp=0 PUSH -> sp=2047; sp=2047 POP reads address 0).
REQ-022 SHALL assert stall only in the IDLE cycle of PUSH2/POP2; single-word ops complete in one cycle, never stall.
REQ-023 SHALL assert mem_read and mem_write mutually exclusively, both 0 when idle/NOP; mem_addr, mem_wd = 0 when neither is asserted.
REQ-024 SHALL pulse rdata_valid for exactly one cycle per completed LOAD/POP/POP2; rdata holds its value until the next completion.
REQ-025 SHALL ignore op_valid deassertion in SECOND (the held op completes).

Reset
REQ-026 SHALL on rst=1 at a clock edge: state=IDLE, sp=2**ADDR_W-1 (2047), rdata=0, rdata_valid=0, holding register=0; stall, mem_read, mem_write = 0 while rst is high.
REQ-027 SHALL give rst priority over any request; rst during SECOND abandons the op (half-written PUSH2 word remains in memory, sp not updated).

Structure
REQ-028 SHALL place op encodings, FSM state encodings, ADDR_W and SP_RESET in shared package mem_pkg.
REQ-029 SHALL implement the stack pointer as sub-module stack_pointer (register with hold, +1, +2, -1, -2, synchronous reset to SP_RESET).

Verification
REQ-030 Reset then PUSH wdata=16'hABCD -> write addr 2047 data ABCD, sp=2046; POP -> read addr 2047, rdata=0000ABCD valid next cycle, sp=2047.
REQ-031 PUSH2 wdata=32'h12345678 from sp=2047 -> cycle1 write 1234@2047 stall=1, cycle2 write 5678@2046 stall=0, sp=2045; POP2 -> reads 2046 then 2047, rdata=12345678, sp=2047.
REQ-032 STORE ea=5 wdata=16'h00FF then LOAD ea=5 -> rdata=000000FF, rdata_valid one cycle; sp unchanged at 2047.
REQ-033 Force sp=0 via 2047 PUSH ops... then PUSH -> write at 0, sp=2047 (wrap); POP from sp=2047 -> read addr 0.
REQ-034 rst asserted in SECOND of PUSH2 -> next cycle state IDLE, sp=2047, stall=0, rdata_valid=0; first word remains at 2047.
REQ-035 op=7 with op_valid=1 -> no memory access, no stall, sp and rdata unchanged.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory access controller: request codes,
// FSM states, stack-pointer commands and default address geometry.
package mem_pkg;

    localparam int unsigned ADDR_W = 11;
    localparam logic [ADDR_W-1:0] SP_RESET = '1;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_LOAD  = 3'd1,
        OP_STORE = 3'd2,
        OP_PUSH  = 3'd3,
        OP_POP   = 3'd4,
        OP_PUSH2 = 3'd5,
        OP_POP2  = 3'd6
    } op_e;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_SECOND = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        SP_HOLD = 3'd0,
        SP_INC1 = 3'd1,
        SP_INC2 = 3'd2,
        SP_DEC1 = 3'd3,
        SP_DEC2 = 3'd4
    } sp_cmd_e;

endpackage

// File: rtl/mem_access_ctrl_stack_pointer.sv
// Stack pointer register: hold, +1, +2, -1, -2, all modulo 2**ADDR_W,
// with synchronous reset to the top of the full-descending stack.
module stack_pointer #(
    parameter int unsigned        ADDR_W  = 11,
    parameter logic [ADDR_W-1:0]  RST_VAL = '1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  mem_pkg::sp_cmd_e      cmd,
    output logic [ADDR_W-1:0]     sp
);
    import mem_pkg::*;

    always_ff @(posedge clk) begin
        if (rst) begin
            sp <= RST_VAL;
        end else begin
            case (cmd)
                SP_INC1: sp <= sp + ADDR_W'(1);
                SP_INC2: sp <= sp + ADDR_W'(2);
                SP_DEC1: sp <= sp - ADDR_W'(1);
                SP_DEC2: sp <= sp - ADDR_W'(2);
                default: sp <= sp;
            endcase
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// EX/MEM data-memory access controller: LOAD/STORE plus single- and
// double-word stack operations over a single-ported synchronous-write memory.
module mem_access_ctrl #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned ADDR_W    = 11
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    op_valid,
    input  logic [2:0]              op,
    input  logic [ADDR_W-1:0]       ea,
    input  logic [2*WORD_SIZE-1:0]  wdata,
    output logic                    stall,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [WORD_SIZE-1:0]    mem_wd,
    input  logic [WORD_SIZE-1:0]    mem_rd,
    output logic [2*WORD_SIZE-1:0]  rdata,
    output logic                    rdata_valid,
    output logic [ADDR_W-1:0]       sp
);
    import mem_pkg::*;

    state_e                 state, state_nxt;
    logic                   second_push, second_push_nxt;
    logic [WORD_SIZE-1:0]   hold, hold_nxt;
    logic                   rd_done;
    logic [2*WORD_SIZE-1:0] rdata_nxt;
    sp_cmd_e                sp_cmd;
    logic [ADDR_W-1:0]      sp_p1, sp_p2, sp_m1;

    assign sp_p1 = sp + ADDR_W'(1);
    assign sp_p2 = sp + ADDR_W'(2);
    assign sp_m1 = sp - ADDR_W'(1);

    stack_pointer #(
        .ADDR_W  (ADDR_W),
        .RST_VAL ('1)
    ) u_sp (
        .clk (clk),
        .rst (rst),
        .cmd (sp_cmd),
        .sp  (sp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            second_push <= 1'b0;
            hold        <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            second_push <= second_push_nxt;
            hold        <= hold_nxt;
            rdata_valid <= rd_done;
            if (rd_done) begin
                rdata <= rdata_nxt;
            end
        end
    end

    // The holding register carries the PUSH2 low word or the POP2 low word
    // into SECOND, so the second cycle never depends on upstream inputs.
    always_comb begin
        state_nxt       = state;
        second_push_nxt = second_push;
        hold_nxt        = hold;
        sp_cmd          = SP_HOLD;
        stall           = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_addr        = '0;
        mem_wd          = '0;
        rd_done         = 1'b0;
        rdata_nxt       = rdata;

        if (!rst) begin
            case (state)
                S_IDLE: begin
                    if (op_valid) begin
                        case (op)
                            OP_LOAD: begin
                                mem_read  = 1'b1;
                                mem_addr  = ea;
                                rd_done   = 1'b1;
                                rdata_nxt = {{WORD_SIZE{1'b0}}, mem_rd};
                            end
                            OP_STORE: begin
                                mem_write = 1'b1;
                                mem_addr  = ea;
                                mem_wd    = wdata[WORD_SIZE-1:0];
                            end
                            OP_PUSH: begin
                                mem_write = 1'b1;
                                mem_addr  = sp;
                                mem_wd    = wdata[WORD_SIZE-1:0];
                                sp_cmd    = SP_DEC1;
                            end
                            OP_POP: begin
                                mem_read  = 1'b1;
                                mem_addr  = sp_p1;
                                sp_cmd    = SP_INC1;
                                rd_done   = 1'b1;
                                rdata_nxt = {{WORD_SIZE{1'b0}}, mem_rd};
                            end
                            OP_PUSH2: begin
                                mem_write       = 1'b1;
                                mem_addr        = sp;
                                mem_wd          = wdata[2*WORD_SIZE-1:WORD_SIZE];
                                stall           = 1'b1;
                                hold_nxt        = wdata[WORD_SIZE-1:0];
                                second_push_nxt = 1'b1;
                                state_nxt       = S_SECOND;
                            end
                            OP_POP2: begin
                                mem_read        = 1'b1;
                                mem_addr        = sp_p1;
                                stall           = 1'b1;
                                hold_nxt        = mem_rd;
                                second_push_nxt = 1'b0;
                                state_nxt       = S_SECOND;
                            end
                            default: ;
                        endcase
                    end
                end
                S_SECOND: begin
                    state_nxt = S_IDLE;
                    if (second_push) begin
                        mem_write = 1'b1;
                        mem_addr  = sp_m1;
                        mem_wd    = hold;
                        sp_cmd    = SP_DEC2;
                    end else begin
                        mem_read  = 1'b1;
                        mem_addr  = sp_p2;
                        sp_cmd    = SP_INC2;
                        rd_done   = 1'b1;
                        rdata_nxt = {mem_rd, hold};
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural data memory attached
// to the memory port; expected values are hand-computed constants.
module tb_mem_access_ctrl;

    localparam logic [2:0] NOP   = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] STORE = 3'd2;
    localparam logic [2:0] PUSH  = 3'd3;
    localparam logic [2:0] POP   = 3'd4;
    localparam logic [2:0] PUSH2 = 3'd5;
    localparam logic [2:0] POP2  = 3'd6;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op;
    logic [10:0] ea;
    logic [31:0] wdata;
    logic        stall;
    logic        mem_read;
    logic        mem_write;
    logic [10:0] mem_addr;
    logic [15:0] mem_wd;
    logic [15:0] mem_rd;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic [10:0] sp;

    logic [15:0] mem [0:2047];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wd;
    end

    mem_access_ctrl #(
        .WORD_SIZE (16),
        .ADDR_W    (11)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .op_valid    (op_valid),
        .op          (op),
        .ea          (ea),
        .wdata       (wdata),
        .stall       (stall),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wd      (mem_wd),
        .mem_rd      (mem_rd),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .sp          (sp)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic setop(input logic v, input logic [2:0] o, input logic [10:0] a, input logic [31:0] d);
        @(negedge clk);
        op_valid = v;
        op       = o;
        ea       = a;
        wdata    = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; op_valid = 1'b0; op = NOP; ea = '0; wdata = '0;
        tick(); tick();
        chk("rst_sp",     32'(sp), 32'd2047);
        chk("rst_rdata",  rdata, 32'h0);
        chk("rst_valid",  32'(rdata_valid), 32'd0);
        chk("rst_stall",  32'(stall), 32'd0);
        chk("rst_rd_wr",  32'({mem_read, mem_write}), 32'd0);

        // PUSH ABCD
        @(negedge clk); rst = 1'b0;
        setop(1'b1, PUSH, 11'd0, 32'h0000ABCD);
        #1;
        chk("push_wr",    32'({mem_read, mem_write}), 32'd1);
        chk("push_addr",  32'(mem_addr), 32'd2047);
        chk("push_wd",    32'(mem_wd), 32'h0000ABCD);
        chk("push_stall", 32'(stall), 32'd0);
        tick();
        chk("push_sp",    32'(sp), 32'd2046);
        chk("push_nv",    32'(rdata_valid), 32'd0);

        // POP
        setop(1'b1, POP, 11'd0, 32'h0);
        #1;
        chk("pop_rd",     32'({mem_read, mem_write}), 32'd2);
        chk("pop_addr",   32'(mem_addr), 32'd2047);
        tick();
        chk("pop_sp",     32'(sp), 32'd2047);
        chk("pop_rdata",  rdata, 32'h0000ABCD);
        chk("pop_valid",  32'(rdata_valid), 32'd1);

        // idle: one-cycle valid pulse, rdata held, port quiet
        setop(1'b0, NOP, 11'd0, 32'h0);
        #1;
        chk("idle_rd_wr", 32'({mem_read, mem_write}), 32'd0);
        chk("idle_addr",  32'(mem_addr), 32'd0);
        chk("idle_wd",    32'(mem_wd), 32'd0);
        tick();
        chk("idle_valid", 32'(rdata_valid), 32'd0);
        chk("idle_rdata", rdata, 32'h0000ABCD);

        // PUSH2 12345678, op_valid dropped during SECOND
        setop(1'b1, PUSH2, 11'd0, 32'h12345678);
        #1;
        chk("p2a_wr",     32'({mem_read, mem_write}), 32'd1);
        chk("p2a_addr",   32'(mem_addr), 32'd2047);
        chk("p2a_wd",     32'(mem_wd), 32'h00001234);
        chk("p2a_stall",  32'(stall), 32'd1);
        tick();
        chk("p2a_sp",     32'(sp), 32'd2047);
        setop(1'b0, NOP, 11'd0, 32'h0);
        #1;
        chk("p2b_wr",     32'({mem_read, mem_write}), 32'd1);
        chk("p2b_addr",   32'(mem_addr), 32'd2046);
        chk("p2b_wd",     32'(mem_wd), 32'h00005678);
        chk("p2b_stall",  32'(stall), 32'd0);
        tick();
        chk("p2b_sp",     32'(sp), 32'd2045);

        // POP2
        setop(1'b1, POP2, 11'd0, 32'h0);
        #1;
        chk("q2a_rd",     32'({mem_read, mem_write}), 32'd2);
        chk("q2a_addr",   32'(mem_addr), 32'd2046);
        chk("q2a_stall",  32'(stall), 32'd1);
        tick();
        chk("q2a_sp",     32'(sp), 32'd2045);
        chk("q2a_nv",     32'(rdata_valid), 32'd0);
        #1;
        chk("q2b_addr",   32'(mem_addr), 32'd2047);
        chk("q2b_stall",  32'(stall), 32'd0);
        tick();
        chk("q2b_sp",     32'(sp), 32'd2047);
        chk("q2b_rdata",  rdata, 32'h12345678);
        chk("q2b_valid",  32'(rdata_valid), 32'd1);

        // STORE then LOAD at ea=5
        setop(1'b1, STORE, 11'd5, 32'h000000FF);
        #1;
        chk("st_wr",      32'({mem_read, mem_write}), 32'd1);
        chk("st_addr",    32'(mem_addr), 32'd5);
        chk("st_wd",      32'(mem_wd), 32'h000000FF);
        tick();
        chk("st_nv",      32'(rdata_valid), 32'd0);
        setop(1'b1, LOAD, 11'd5, 32'h0);
        #1;
        chk("ld_rd",      32'({mem_read, mem_write}), 32'd2);
        tick();
        chk("ld_rdata",   rdata, 32'h000000FF);
        chk("ld_valid",   32'(rdata_valid), 32'd1);
        chk("ld_sp",      32'(sp), 32'd2047);

        // illegal op code 7
        setop(1'b1, 3'd7, 11'd9, 32'hFFFFFFFF);
        #1;
        chk("op7_rd_wr",  32'({mem_read, mem_write}), 32'd0);
        chk("op7_stall",  32'(stall), 32'd0);
        chk("op7_addr",   32'(mem_addr), 32'd0);
        tick();
        chk("op7_sp",     32'(sp), 32'd2047);
        chk("op7_rdata",  rdata, 32'h000000FF);
        chk("op7_valid",  32'(rdata_valid), 32'd0);

        // reset in SECOND of PUSH2 abandons the op
        setop(1'b1, PUSH2, 11'd0, 32'hAAAABBBB);
        tick();
        @(negedge clk); rst = 1'b1;
        #1;
        chk("rs2_wr",     32'(mem_write), 32'd0);
        chk("rs2_stall",  32'(stall), 32'd0);
        tick();
        chk("rs2_sp",     32'(sp), 32'd2047);
        chk("rs2_valid",  32'(rdata_valid), 32'd0);
        chk("rs2_rdata",  rdata, 32'h0);
        @(negedge clk); rst = 1'b0;
        op_valid = 1'b0; op = NOP;
        #1;
        chk("rs2_idle",   32'({stall, mem_read, mem_write}), 32'd0);
        setop(1'b1, LOAD, 11'd2047, 32'h0);
        tick();
        chk("rs2_hi_kept", rdata, 32'h0000AAAA);
        setop(1'b1, LOAD, 11'd2046, 32'h0);
        tick();
        chk("rs2_lo_old", rdata, 32'h00005678);

        // wrap: 2047 pushes bring sp to 0, one more wraps to 2047
        for (int i = 0; i < 2047; i++) begin
            setop(1'b1, PUSH, 11'd0, 32'(i));
            @(posedge clk);
        end
        #1;
        chk("wrap_sp0",   32'(sp), 32'd0);
        setop(1'b1, PUSH, 11'd0, 32'h0000BEEF);
        #1;
        chk("wrap_paddr", 32'(mem_addr), 32'd0);
        tick();
        chk("wrap_sp",    32'(sp), 32'd2047);
        setop(1'b1, POP, 11'd0, 32'h0);
        #1;
        chk("wrap_qaddr", 32'(mem_addr), 32'd0);
        tick();
        chk("wrap_rdata", rdata, 32'h0000BEEF);
        chk("wrap_qsp",   32'(sp), 32'd0);

        setop(1'b0, NOP, 11'd0, 32'h0);
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
